// File: rtl/dc_accel_pkg.sv
// Shared types and helpers for the multi-outstanding accelerator-to-FIFO bridge.
// Contents: default parameter values, the channel-id type stored in the ID FIFO,
// and the round-robin pick function used by the arbiter.
package dc_accel_pkg;

  localparam int unsigned MAX_CH        = 16;
  localparam int unsigned CH_ID_W       = 4;  // $clog2(MAX_CH)
  localparam int unsigned DEF_NB_CH     = 4;
  localparam int unsigned DEF_AW        = 32;
  localparam int unsigned DEF_DW        = 32;
  localparam int unsigned DEF_MAX_OUTST = 4;

  // Wide enough for any legal channel count, so the FIFO type does not
  // depend on the instance's NB_CH.
  typedef logic [CH_ID_W-1:0] ch_id_t;

  // First requesting channel at or after ptr, wrapping at nb_ch.
  // Returns ptr when nothing requests (the caller gates on |req).
  function automatic ch_id_t rr_pick(input logic [MAX_CH-1:0] req,
                                     input ch_id_t            ptr,
                                     input int unsigned       nb_ch);
    ch_id_t      pick;
    logic        found;
    int unsigned idx;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= nb_ch) idx = idx - nb_ch;
      if ((i < nb_ch) && !found && req[idx[3:0]]) begin
        pick  = ch_id_t'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/dc_accel_id_fifo.sv
// Synchronous FIFO of channel ids; remembers which channel owns each in-flight
// master transaction so responses can be routed back in order.
// Ports: clk_i, rst_i (sync, active high), push/wdata, pop/rdata,
//        full, empty, count (occupancy, registered).
// Push while full and pop while empty are ignored.
module dc_accel_id_fifo
  import dc_accel_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push,
  input  logic          pop,
  input  ch_id_t        wdata,
  output ch_id_t        rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ch_id_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dc_accel_mo_bridge.sv
// Round-robin bridge from NB_CH accelerator TCDM-style slave channels onto one
// L2 DC-FIFO master port, with up to MAX_OUTST transactions in flight.
// Ports: clk_i, rst_i (sync, active high);
//        ch_* : per-channel req/gnt/payload in, registered r_valid out plus a
//               shared registered r_rdata;
//        m_*  : master req/payload out, gnt and response in;
//        outst_o : ID FIFO occupancy; err_o : sticky unsolicited-response flag.
module dc_accel_mo_bridge
  import dc_accel_pkg::*;
#(
  parameter int unsigned NB_CH     = DEF_NB_CH,
  parameter int unsigned AW        = DEF_AW,
  parameter int unsigned DW        = DEF_DW,
  parameter int unsigned MAX_OUTST = DEF_MAX_OUTST
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NB_CH-1:0]               ch_req_i,
  output logic [NB_CH-1:0]               ch_gnt_o,
  input  logic [NB_CH*AW-1:0]            ch_add_i,
  input  logic [NB_CH-1:0]               ch_wen_i,
  input  logic [NB_CH*DW-1:0]            ch_wdata_i,
  input  logic [NB_CH*DW/8-1:0]          ch_be_i,
  output logic [NB_CH-1:0]               ch_r_valid_o,
  output logic [DW-1:0]                  ch_r_rdata_o,
  output logic                           m_req_o,
  input  logic                           m_gnt_i,
  output logic [AW-1:0]                  m_add_o,
  output logic                           m_wen_o,
  output logic [DW-1:0]                  m_wdata_o,
  output logic [DW/8-1:0]                m_be_o,
  input  logic                           m_r_valid_i,
  input  logic [DW-1:0]                  m_r_rdata_i,
  output logic [$clog2(MAX_OUTST+1)-1:0] outst_o,
  output logic                           err_o
);

  localparam int unsigned BW = DW / 8;

  logic [MAX_CH-1:0] req_pad;
  ch_id_t            rr_ptr;
  ch_id_t            sel;
  ch_id_t            resp_id;
  logic              id_full;
  logic              id_empty;
  logic              xfer;
  logic              pop;
  logic [NB_CH-1:0]  resp_onehot;

  assign req_pad = MAX_CH'(ch_req_i);
  assign sel     = rr_pick(req_pad, rr_ptr, NB_CH);

  // Blocked in the reset cycle so nothing is granted into a FIFO that is
  // about to be cleared.
  assign m_req_o = (|ch_req_i) & ~id_full & ~rst_i;
  assign xfer    = m_req_o & m_gnt_i;
  assign pop     = m_r_valid_i & ~id_empty;

  always_comb begin
    m_add_o     = '0;
    m_wen_o     = 1'b0;
    m_wdata_o   = '0;
    m_be_o      = '0;
    ch_gnt_o    = '0;
    resp_onehot = '0;
    for (int unsigned i = 0; i < NB_CH; i++) begin
      if (sel == ch_id_t'(i)) begin
        m_add_o     = ch_add_i[i*AW +: AW];
        m_wen_o     = ch_wen_i[i];
        m_wdata_o   = ch_wdata_i[i*DW +: DW];
        m_be_o      = ch_be_i[i*BW +: BW];
        ch_gnt_o[i] = xfer;
      end
      resp_onehot[i] = (resp_id == ch_id_t'(i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= (sel == ch_id_t'(NB_CH - 1)) ? '0 : sel + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ch_r_valid_o <= '0;
      ch_r_rdata_o <= '0;
      err_o        <= 1'b0;
    end else begin
      ch_r_valid_o <= '0;
      if (pop) begin
        ch_r_valid_o <= resp_onehot;
        ch_r_rdata_o <= m_r_rdata_i;
      end
      if (m_r_valid_i & id_empty) err_o <= 1'b1;
    end
  end

  dc_accel_id_fifo #(
    .DEPTH (MAX_OUTST),
    .CW    ($clog2(MAX_OUTST + 1))
  ) u_id_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (xfer),
    .pop   (pop),
    .wdata (sel),
    .rdata (resp_id),
    .full  (id_full),
    .empty (id_empty),
    .count (outst_o)
  );

endmodule

// File: tb/tb_dc_accel_mo_bridge.sv
// Scoreboard bench: the driver computes expected grants/requests from a queue
// model of in-flight channel ids and pushes expected responses into a queue;
// a separate monitor pops and compares whenever the response outputs are due.
module tb_dc_accel_mo_bridge;

  localparam int NB_CH     = 4;
  localparam int AW        = 32;
  localparam int DW        = 32;
  localparam int BW        = DW / 8;
  localparam int MAX_OUTST = 4;
  localparam int OW        = $clog2(MAX_OUTST + 1);

  logic                  clk_i = 1'b0;
  logic                  rst_i = 1'b1;
  logic [NB_CH-1:0]      ch_req_i = '0;
  logic [NB_CH-1:0]      ch_gnt_o;
  logic [NB_CH*AW-1:0]   ch_add_i = '0;
  logic [NB_CH-1:0]      ch_wen_i = '0;
  logic [NB_CH*DW-1:0]   ch_wdata_i = '0;
  logic [NB_CH*BW-1:0]   ch_be_i = '0;
  logic [NB_CH-1:0]      ch_r_valid_o;
  logic [DW-1:0]         ch_r_rdata_o;
  logic                  m_req_o;
  logic                  m_gnt_i = 1'b0;
  logic [AW-1:0]         m_add_o;
  logic                  m_wen_o;
  logic [DW-1:0]         m_wdata_o;
  logic [BW-1:0]         m_be_o;
  logic                  m_r_valid_i = 1'b0;
  logic [DW-1:0]         m_r_rdata_i = '0;
  logic [OW-1:0]         outst_o;
  logic                  err_o;

  dc_accel_mo_bridge #(
    .NB_CH(NB_CH), .AW(AW), .DW(DW), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ch_req_i(ch_req_i), .ch_gnt_o(ch_gnt_o), .ch_add_i(ch_add_i),
    .ch_wen_i(ch_wen_i), .ch_wdata_i(ch_wdata_i), .ch_be_i(ch_be_i),
    .ch_r_valid_o(ch_r_valid_o), .ch_r_rdata_o(ch_r_rdata_o),
    .m_req_o(m_req_o), .m_gnt_i(m_gnt_i), .m_add_o(m_add_o),
    .m_wen_o(m_wen_o), .m_wdata_o(m_wdata_o), .m_be_o(m_be_o),
    .m_r_valid_i(m_r_valid_i), .m_r_rdata_i(m_r_rdata_i),
    .outst_o(outst_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          ch;
    logic [31:0] data;
  } resp_t;

  int    n_cmp = 0;
  int    n_err = 0;
  bit    mon_en = 1'b0;
  int    inflight[$];
  resp_t exp_q[$];
  int    m_ptr = 0;
  bit    m_err = 1'b0;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic int model_pick(logic [NB_CH-1:0] req, int p);
    for (int k = 0; k < NB_CH; k++)
      if (req[(p + k) % NB_CH]) return (p + k) % NB_CH;
    return p;
  endfunction

  // Checks the combinational/registered outputs for the current inputs, then
  // advances the model by the clock edge that is about to happen.
  task automatic eval_cycle();
    int               occ;
    bit               full;
    bit               mreq;
    int               s;
    int               h;
    logic [NB_CH-1:0] egnt;
    resp_t            r;
    occ  = inflight.size();
    full = (occ == MAX_OUTST);
    mreq = (|ch_req_i) && !full && !rst_i;
    s    = model_pick(ch_req_i, m_ptr);
    egnt = (mreq && m_gnt_i) ? (NB_CH'(1) << s) : '0;
    check("m_req", 64'(m_req_o), 64'(mreq));
    check("ch_gnt", 64'(ch_gnt_o), 64'(egnt));
    check("outst", 64'(outst_o), 64'(occ));
    check("err", 64'(err_o), 64'(m_err));
    if (mreq) begin
      check("m_add", 64'(m_add_o), 64'(ch_add_i[s*AW +: AW]));
      check("m_wen", 64'(m_wen_o), 64'(ch_wen_i[s]));
      check("m_wdata", 64'(m_wdata_o), 64'(ch_wdata_i[s*DW +: DW]));
      check("m_be", 64'(m_be_o), 64'(ch_be_i[s*BW +: BW]));
    end
    if (rst_i) begin
      inflight.delete();
      exp_q.delete();
      m_ptr = 0;
      m_err = 1'b0;
    end else begin
      if (m_r_valid_i) begin
        if (occ > 0) begin
          h = inflight.pop_front();
          r.ch = h;
          r.data = m_r_rdata_i;
          exp_q.push_back(r);
        end else begin
          m_err = 1'b1;
        end
      end
      if (mreq && m_gnt_i) begin
        inflight.push_back(s);
        m_ptr = (s + 1) % NB_CH;
      end
    end
  endtask

  task automatic step(input logic [NB_CH-1:0] req, input logic gnt, input logic rv,
                      input logic [DW-1:0] rd, input bit hold);
    ch_req_i    = req;
    m_gnt_i     = gnt;
    m_r_valid_i = rv;
    m_r_rdata_i = rd;
    if (!hold) begin
      for (int i = 0; i < NB_CH; i++) begin
        ch_add_i[i*AW +: AW]   = $urandom;
        ch_wen_i[i]            = 1'($urandom_range(0, 1));
        ch_wdata_i[i*DW +: DW] = $urandom;
        ch_be_i[i*BW +: BW]    = BW'($urandom);
      end
    end
    @(negedge clk_i);
    #1;
    eval_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 2 * MAX_OUTST; k++) begin
      if (inflight.size() == 0) break;
      step('0, 1'b0, 1'b1, $urandom, 1'b0);
    end
    step('0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step('0, 1'b0, 1'b0, '0, 1'b0);
    rst_i = 1'b0;
  endtask

  // Response monitor: one expected entry is due per cycle it was pushed for.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk_i);
      if (mon_en) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("r_valid", 64'(ch_r_valid_o), 64'(NB_CH'(1) << e.ch));
          check("r_rdata", 64'(ch_r_rdata_o), 64'(e.data));
        end else begin
          check("r_valid_idle", 64'(ch_r_valid_o), 64'd0);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] held_add;
    repeat (2) @(posedge clk_i);
    #1;
    step('1, 1'b1, 1'b1, 32'h1234_5678, 1'b0);   // reset cycle: no request out
    check("rst_r_valid", 64'(ch_r_valid_o), 64'd0);
    check("rst_r_rdata", 64'(ch_r_rdata_o), 64'd0);
    check("rst_outst", 64'(outst_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    rst_i  = 1'b0;
    mon_en = 1'b1;

    // Single read on ch2, response three cycles later.
    step(4'b0100, 1'b1, 1'b0, '0, 1'b0);
    step('0, 1'b0, 1'b0, '0, 1'b0);
    step('0, 1'b0, 1'b0, '0, 1'b0);
    step('0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    step('0, 1'b0, 1'b0, '0, 1'b0);
    check("single_rdata_hold", 64'(ch_r_rdata_o), 64'hDEAD_BEEF);

    // All channels requesting, responses streaming.
    for (int k = 0; k < 8; k++) step('1, 1'b1, 1'(k >= 1), $urandom, 1'b0);
    drain();

    // Fill to MAX_OUTST, then full + pop + pending request.
    for (int k = 0; k < MAX_OUTST; k++) step('1, 1'b1, 1'b0, '0, 1'b0);
    step('1, 1'b1, 1'b0, '0, 1'b0);
    step(4'b0010, 1'b1, 1'b1, $urandom, 1'b0);
    step(4'b0010, 1'b1, 1'b0, '0, 1'b0);
    check("full_refill_outst", 64'(outst_o), 64'(MAX_OUTST));
    drain();

    // Unsolicited response.
    step('0, 1'b0, 1'b1, $urandom, 1'b0);
    for (int k = 0; k < 3; k++) step('0, 1'b0, 1'b0, '0, 1'b0);
    check("err_sticky", 64'(err_o), 64'd1);
    do_reset();

    // Reset with three in flight; a response in the reset cycle is dropped.
    for (int k = 0; k < 3; k++) step('1, 1'b1, 1'b0, '0, 1'b0);
    rst_i = 1'b1;
    step('0, 1'b0, 1'b1, $urandom, 1'b0);
    rst_i = 1'b0;
    check("post_rst_outst", 64'(outst_o), 64'd0);
    check("post_rst_r_valid", 64'(ch_r_valid_o), 64'd0);
    check("post_rst_m_req", 64'(m_req_o), 64'd0);
    step('0, 1'b0, 1'b1, $urandom, 1'b0);
    step('0, 1'b0, 1'b0, '0, 1'b0);
    check("late_resp_err", 64'(err_o), 64'd1);
    do_reset();

    // Master stalls with ch1 requesting; payload held stable.
    step(4'b0001, 1'b1, 1'b0, '0, 1'b0);             // pointer moves to 1
    step(4'b0010, 1'b0, 1'b0, '0, 1'b0);
    held_add = ch_add_i[1*AW +: AW];
    for (int k = 0; k < 4; k++) begin
      step(4'b0010, 1'b0, 1'b0, '0, 1'b1);
      check("stall_add", 64'(m_add_o), 64'(held_add));
    end
    step(4'b1011, 1'b1, 1'b0, '0, 1'b1);             // ch1 still first after stall
    drain();

    // Randomised traffic.
    for (int k = 0; k < 400; k++)
      step(NB_CH'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 9) < 4), $urandom, 1'b0);
    drain();
    step('0, 1'b0, 1'b0, '0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
